// File: rtl/core_pkg.sv
// Shared definitions for the cpu_core front end: default widths, reset PC, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

   localparam int          ADDR_W_DEF   = 64;
   localparam int          INST_W_DEF   = 32;
   localparam logic [63:0] RESET_PC_DEF = 64'h0;

   // FETCH issues and keeps responses; DISCARD waits out a response made stale by a redirect.
   typedef enum logic {
      FETCH   = 1'b0,
      DISCARD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; head entry is presented combinationally.
// Latency: a push is visible at the head on the next clock edge.
// Backpressure: push is ignored when full, pop is ignored when empty; flush wins over both.
module fetch_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && (count != DEPTH_C) && !flush;
   assign pop_ok  = pop && (count != '0) && !flush;

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
         end
      end
   end

   // Entry storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, one outstanding memory request, prefetch FIFO to decode.
// Latency: a memory response is visible at decode one clock edge later; redirect re-issues next cycle or after the stale response.
// Backpressure: requests stop while the FIFO is full; decode stalls hold the head via id_ready.
module fetch_unit
   import core_pkg::*;
#(
   parameter int                ADDR_W     = ADDR_W_DEF,
   parameter int                INST_W     = INST_W_DEF,
   parameter int                DEPTH      = 4,
   parameter int                INST_BYTES = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_W-1:0]      inst_mem_addr,
   output logic                   inst_addr_valid,
   input  logic                   inst_mem_valid,
   input  logic [INST_W-1:0]      inst_mem_data,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [ADDR_W-1:0]      id_pc,
   output logic [INST_W-1:0]      id_inst,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam int WIDTH = ADDR_W + INST_W;

   fetch_state_t      state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
   logic [ADDR_W-1:0] next_pc, next_pc_nxt;
   logic              push;
   logic              pop;
   logic [WIDTH-1:0]  head_data;

   // State, fetch PC and pending redirect target registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= FETCH;
         fetch_pc <= RESET_PC;
         next_pc  <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         next_pc  <= next_pc_nxt;
      end
   end

   // Next-state, request and push decisions; the address never moves while a request is open.
   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      next_pc_nxt     = next_pc;
      push            = 1'b0;
      inst_addr_valid = 1'b0;
      if (!rst) begin
         case (state)
            FETCH: begin
               inst_addr_valid = (fifo_count < DEPTH_C);
               if (redirect_valid) begin
                  if (inst_addr_valid && !inst_mem_valid) begin
                     next_pc_nxt = redirect_pc;
                     state_nxt   = DISCARD;
                  end else begin
                     fetch_pc_nxt = redirect_pc;
                  end
               end else if (inst_addr_valid && inst_mem_valid) begin
                  push         = 1'b1;
                  fetch_pc_nxt = fetch_pc + ADDR_W'(INST_BYTES);
               end
            end
            DISCARD: begin
               inst_addr_valid = 1'b1;
               if (inst_mem_valid) begin
                  state_nxt    = FETCH;
                  fetch_pc_nxt = redirect_valid ? redirect_pc : next_pc;
               end else if (redirect_valid) begin
                  next_pc_nxt = redirect_pc;
               end
            end
            default: begin
               state_nxt = FETCH;
            end
         endcase
      end
   end

   assign inst_mem_addr = fetch_pc;
   assign id_valid      = (fifo_count != '0);
   assign pop           = id_valid && id_ready && !redirect_valid;
   assign id_pc         = head_data[WIDTH-1:INST_W];
   assign id_inst       = head_data[INST_W-1:0];

   fetch_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({fetch_pc, inst_mem_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (fifo_count),
      .head_data (head_data)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a combinational-response memory stub.
// Latency: each vector spans one clock; outputs are checked at the falling edge.
// Backpressure: id_ready and inst_mem_valid are scripted per vector.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] inst_mem_addr;
   logic        inst_addr_valid;
   logic        inst_mem_valid;
   logic [31:0] inst_mem_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  fifo_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDR_W     (64),
      .INST_W     (32),
      .DEPTH      (4),
      .INST_BYTES (4),
      .RESET_PC   (64'h1000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_mem_addr   (inst_mem_addr),
      .inst_addr_valid (inst_addr_valid),
      .inst_mem_valid  (inst_mem_valid),
      .inst_mem_data   (inst_mem_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_pc           (id_pc),
      .id_inst         (id_inst),
      .fifo_count      (fifo_count)
   );

   typedef struct {
      logic        mv;
      logic        rdy;
      logic        rv;
      logic [63:0] rpc;
      logic        e_av;
      logic [63:0] e_addr;
      logic        e_iv;
      logic [63:0] e_ipc;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs [64];
   int   n_tab = 0;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0000;
   endfunction

   task automatic add(input logic mv, input logic rdy, input logic rv, input logic [63:0] rpc,
                      input logic e_av, input logic [63:0] e_addr, input logic e_iv,
                      input logic [63:0] e_ipc, input logic [2:0] e_cnt);
      vecs[n_tab] = '{mv, rdy, rv, rpc, e_av, e_addr, e_iv, e_ipc, e_cnt};
      n_tab++;
   endtask

   // One vector's worth of output checks against hand-computed expectations.
   task automatic check(input string nm, input logic e_av, input logic [63:0] e_addr,
                        input logic e_iv, input logic [63:0] e_ipc, input logic [2:0] e_cnt);
      logic [31:0] e_inst;
      e_inst = e_iv ? inst_of(e_ipc) : 32'h0;
      n_vec++;
      if (inst_addr_valid !== e_av) begin
         n_bad++; $display("FAIL %s inst_addr_valid got %b want %b", nm, inst_addr_valid, e_av);
      end
      if (e_av && inst_mem_addr !== e_addr) begin
         n_bad++; $display("FAIL %s inst_mem_addr got %h want %h", nm, inst_mem_addr, e_addr);
      end
      if (id_valid !== e_iv) begin
         n_bad++; $display("FAIL %s id_valid got %b want %b", nm, id_valid, e_iv);
      end
      if (id_pc !== e_ipc) begin
         n_bad++; $display("FAIL %s id_pc got %h want %h", nm, id_pc, e_ipc);
      end
      if (id_inst !== e_inst) begin
         n_bad++; $display("FAIL %s id_inst got %h want %h", nm, id_inst, e_inst);
      end
      if (fifo_count !== e_cnt) begin
         n_bad++; $display("FAIL %s fifo_count got %0d want %0d", nm, fifo_count, e_cnt);
      end
   endtask

   initial begin
      // Sequential fetch with same-cycle memory and decode always ready.
      add(1, 1, 0, 0,      1, 64'h1000, 0, 64'h0,    3'd0);
      add(1, 1, 0, 0,      1, 64'h1004, 1, 64'h1000, 3'd1);
      add(1, 1, 0, 0,      1, 64'h1008, 1, 64'h1004, 3'd1);
      // Decode stalled for 10 cycles: FIFO fills to DEPTH and requests stop.
      add(1, 0, 0, 0,      1, 64'h100C, 1, 64'h1008, 3'd1);
      add(1, 0, 0, 0,      1, 64'h1010, 1, 64'h1008, 3'd2);
      add(1, 0, 0, 0,      1, 64'h1014, 1, 64'h1008, 3'd3);
      for (int i = 0; i < 7; i++)
         add(1, 0, 0, 0,   0, 64'h1018, 1, 64'h1008, 3'd4);
      // Release: drain in order with no lost or duplicated PC.
      add(1, 1, 0, 0,      0, 64'h1018, 1, 64'h1008, 3'd4);
      add(1, 1, 0, 0,      1, 64'h1018, 1, 64'h100C, 3'd3);
      add(0, 1, 0, 0,      1, 64'h101C, 1, 64'h1010, 3'd3);
      add(0, 1, 0, 0,      1, 64'h101C, 1, 64'h1014, 3'd2);
      add(0, 1, 0, 0,      1, 64'h101C, 1, 64'h1018, 3'd1);
      add(1, 1, 0, 0,      1, 64'h101C, 0, 64'h0,    3'd0);
      // Slow memory: redirect the cycle after the request to 0x1020; the response is dropped.
      add(0, 1, 1, 64'h2000, 1, 64'h1020, 1, 64'h101C, 3'd1);
      add(0, 1, 0, 0,      1, 64'h1020, 0, 64'h0,    3'd0);
      add(1, 1, 0, 0,      1, 64'h1020, 0, 64'h0,    3'd0);
      add(1, 0, 0, 0,      1, 64'h2000, 0, 64'h0,    3'd0);
      // Redirect coincident with a response and a pop: nothing pushed, FIFO flushed.
      add(1, 1, 1, 64'h3000, 1, 64'h2004, 1, 64'h2000, 3'd1);
      // Two redirects during DISCARD: the last target wins.
      add(0, 1, 1, 64'h4000, 1, 64'h3000, 0, 64'h0,    3'd0);
      add(0, 1, 1, 64'h5000, 1, 64'h3000, 0, 64'h0,    3'd0);
      add(1, 1, 0, 0,      1, 64'h3000, 0, 64'h0,    3'd0);
      // Redirect coincident with a response to the top of the address space, then wrap.
      add(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h5000, 0, 64'h0, 3'd0);
      add(1, 0, 0, 0,      1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 3'd0);
      add(0, 0, 0, 0,      1, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1);

      rst = 1'b1;
      inst_mem_valid = 1'b0;
      inst_mem_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;

      for (int i = 0; i < n_tab; i++) begin
         check($sformatf("vec%0d", i), vecs[i].e_av, vecs[i].e_addr, vecs[i].e_iv,
               vecs[i].e_ipc, vecs[i].e_cnt);
         inst_mem_valid = vecs[i].mv;
         inst_mem_data  = inst_of(inst_mem_addr);
         id_ready       = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         @(negedge clk);
         #1;
      end

      // Reset asserted while the request to 0x0 is open.
      inst_mem_valid = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      check("pre_rst", 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1);
      rst = 1'b1;
      #1;
      check("rst_async", 1'b0, 64'h0, 1'b0, 64'h0, 3'd0);
      @(negedge clk);
      check("rst_held", 1'b0, 64'h0, 1'b0, 64'h0, 3'd0);
      rst = 1'b0;
      #1;
      check("rst_release", 1'b1, 64'h1000, 1'b0, 64'h0, 3'd0);
      inst_mem_valid = 1'b1;
      inst_mem_data  = inst_of(inst_mem_addr);
      @(negedge clk);
      #1;
      inst_mem_valid = 1'b0;
      check("post_rst_fetch", 1'b1, 64'h1004, 1'b1, 64'h1000, 3'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
